// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: register offsets, field indices and reset defaults.
package timer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PRESCALE = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_COMPARE  = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;
    localparam logic [7:0] OFF_CAPTURE  = 8'h14;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned STATUS_MATCH  = 0;
    localparam int unsigned STATUS_CAP    = 1;

    localparam logic [DATA_W-1:0] RESET_COMPARE_DEF = 32'hFFFF_FFFF;

    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } ctrl_t;

    // Byte-lane merge of write data into an existing register value
    function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_v,
                                                      input logic [DATA_W-1:0] wd,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_ip_if.sv
// Local-bus write/read channel between the processor side and the timer slave.
interface timer_ip_if;
    import timer_pkg::*;

    logic [DATA_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wen;
    logic [STRB_W-1:0] wstrb;
    logic              wready;
    logic [DATA_W-1:0] raddr;
    logic              ren;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output waddr, wdata, wen, wstrb, raddr, ren,
                    input  wready, rdata, rvalid);
    modport slave  (input  waddr, wdata, wen, wstrb, raddr, ren,
                    output wready, rdata, rvalid);
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..reload while enabled and emits a one-cycle tick at the top of each period.
module timer_prescaler #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] reload_i,
    output logic                  tick_c
);

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  wrap_c;

    // >= keeps a shrinking reload from letting pcnt run past it
    assign wrap_c = (pcnt_q >= reload_i);
    assign tick_c = en_i && wrap_c;

    always_comb begin
        pcnt_d = pcnt_q;
        if (!en_i)       pcnt_d = '0;
        else if (wrap_c) pcnt_d = '0;
        else             pcnt_d = pcnt_q + PRESCALE_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pcnt_q <= '0;
        else     pcnt_q <= pcnt_d;
    end

endmodule

// File: rtl/timer_ip.sv
// Memory-mapped 32-bit timer/compare peripheral with level interrupt.
// Optional input-capture block enabled by defining TIMER_CAPTURE_EN.
module timer_ip
    import timer_pkg::*;
#(
    parameter int unsigned       PRESCALE_W    = 16,
    parameter logic [DATA_W-1:0] RESET_COMPARE = RESET_COMPARE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    timer_ip_if.slave  bus,
    output logic       irq
`ifdef TIMER_CAPTURE_EN
    ,input logic       cap_in
`endif
);

    ctrl_t                 ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [DATA_W-1:0]     count_q, count_d;
    logic [DATA_W-1:0]     compare_q, compare_d;
    logic [DATA_W-1:0]     capture_q, capture_d;
    logic                  match_q, match_d;
    logic                  cap_flag_q, cap_flag_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  rvalid_q, wready_q, irq_q, irq_d;

    logic              tick_c, cap_edge_c, hit_c, match_set_c;
    logic              wr_ctrl_c, wr_prescale_c, wr_count_c, wr_compare_c, wr_status_c;
    logic [DATA_W-1:0] prescale_wr_c, rd_mux_c;
    logic              unused_c;

    timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en_i     (ctrl_q.en),
        .reload_i (prescale_q),
        .tick_c   (tick_c)
    );

`ifdef TIMER_CAPTURE_EN
    logic [1:0] cap_sync_q;
    logic       cap_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_sync_q <= '0;
            cap_prev_q <= 1'b0;
        end else begin
            cap_sync_q <= {cap_sync_q[0], cap_in};
            cap_prev_q <= cap_sync_q[1];
        end
    end

    assign cap_edge_c = cap_sync_q[1] && !cap_prev_q;
`else
    assign cap_edge_c = 1'b0;
`endif

    assign wr_ctrl_c     = bus.wen && (bus.waddr[7:0] == OFF_CTRL);
    assign wr_prescale_c = bus.wen && (bus.waddr[7:0] == OFF_PRESCALE);
    assign wr_count_c    = bus.wen && (bus.waddr[7:0] == OFF_COUNT);
    assign wr_compare_c  = bus.wen && (bus.waddr[7:0] == OFF_COMPARE);
    assign wr_status_c   = bus.wen && (bus.waddr[7:0] == OFF_STATUS);

    assign prescale_wr_c = apply_wstrb(DATA_W'(prescale_q), bus.wdata, bus.wstrb);
    assign hit_c         = tick_c && (count_q == compare_q);
    // A software COUNT write owns the cycle: it suppresses both increment and match
    assign match_set_c   = hit_c && !wr_count_c;
    assign unused_c      = ^{bus.waddr[31:8], bus.raddr[31:8], prescale_wr_c[DATA_W-1:PRESCALE_W]};

    // Register file, counter and status next-state
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        compare_d  = compare_q;
        capture_d  = capture_q;
        match_d    = match_q;
        cap_flag_d = cap_flag_q;

        if (tick_c) begin
            if (ctrl_q.periodic && hit_c) count_d = '0;
            else                          count_d = count_q + DATA_W'(1);
        end
        if (wr_count_c)    count_d    = apply_wstrb(count_q, bus.wdata, bus.wstrb);
        if (wr_compare_c)  compare_d  = apply_wstrb(compare_q, bus.wdata, bus.wstrb);
        if (wr_prescale_c) prescale_d = prescale_wr_c[PRESCALE_W-1:0];
        if (wr_ctrl_c && bus.wstrb[0]) begin
            ctrl_d.en       = bus.wdata[CTRL_EN];
            ctrl_d.periodic = bus.wdata[CTRL_PERIODIC];
            ctrl_d.irq_en   = bus.wdata[CTRL_IRQ_EN];
        end

        // W1C first so a same-cycle set wins
        if (wr_status_c && bus.wstrb[0]) begin
            if (bus.wdata[STATUS_MATCH]) match_d    = 1'b0;
            if (bus.wdata[STATUS_CAP])   cap_flag_d = 1'b0;
        end
        if (match_set_c) match_d = 1'b1;
        if (cap_edge_c) begin
            capture_d  = count_q;
            cap_flag_d = 1'b1;
        end

        irq_d = match_d && ctrl_d.irq_en;
    end

    // Read mux sampled on ren
    always_comb begin
        rd_mux_c = '0;
        case (bus.raddr[7:0])
            OFF_CTRL:     rd_mux_c = DATA_W'(ctrl_q);
            OFF_PRESCALE: rd_mux_c = DATA_W'(prescale_q);
            OFF_COUNT:    rd_mux_c = count_q;
            OFF_COMPARE:  rd_mux_c = compare_q;
            OFF_STATUS:   rd_mux_c = DATA_W'({cap_flag_q, match_q});
            OFF_CAPTURE:  rd_mux_c = capture_q;
            default:      rd_mux_c = '0;
        endcase
        rdata_d = bus.ren ? rd_mux_c : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= RESET_COMPARE;
            capture_q  <= '0;
            match_q    <= 1'b0;
            cap_flag_q <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wready_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            capture_q  <= capture_d;
            match_q    <= match_d;
            cap_flag_q <= cap_flag_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= bus.ren;
            wready_q   <= bus.wen;
            irq_q      <= irq_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.wready = wready_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_timer_ip.sv
// Scoreboard bench for timer_ip: read results are queued at issue and checked when rvalid returns.
module tb_timer_ip;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    logic cap_in = 1'b0;

    timer_ip_if bus ();

    timer_ip dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .irq    (irq)
`ifdef TIMER_CAPTURE_EN
        ,.cap_in (cap_in)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic        ren_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the following negedge
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.wen   = 1'b1;
        bus.waddr = {24'h0, a};
        bus.wdata = d;
        bus.wstrb = s;
        @(negedge clk);
        bus.wen = 1'b0;
        check("wready", {31'h0, bus.wready}, 32'h1);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        bus.ren   = 1'b1;
        bus.raddr = {24'h0, a};
        exp_q.push_back(exp);
        @(negedge clk);
        bus.ren = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) ren_seen <= 1'b0;
        else     ren_seen <= bus.ren;
    end

    // Response monitor: rvalid must follow each ren by exactly one cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rvalid || ren_seen)
                check("rvalid", {31'h0, bus.rvalid}, {31'h0, ren_seen});
            if (bus.rvalid) begin
                check("rd_pending", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) check("rdata", bus.rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.wen = 1'b0; bus.ren = 1'b0;
        bus.waddr = '0; bus.wdata = '0; bus.wstrb = '0; bus.raddr = '0;
        repeat (3) @(negedge clk);
        check("rst_rdata",  bus.rdata, 32'h0);
        check("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
        check("rst_wready", {31'h0, bus.wready}, 32'h0);
        check("rst_irq",    {31'h0, irq}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Reset values, unmapped and read-only handling, byte strobes
        rd(8'h00, 32'h0); rd(8'h04, 32'h0); rd(8'h08, 32'h0);
        rd(8'h0C, 32'hFFFF_FFFF); rd(8'h10, 32'h0); rd(8'h14, 32'h0);
        rd(8'h18, 32'h0); rd(8'h20, 32'h0);
        wr(8'h14, 32'h1234_5678, 4'hF);
        wr(8'h24, 32'h1234_5678, 4'hF);
        rd(8'h14, 32'h0); rd(8'h24, 32'h0);
        wr(8'h0C, 32'h1234_5678, 4'b0101);
        rd(8'h0C, 32'hFF34_FF78);
        wr(8'h04, 32'hFFFF_FFFF, 4'hF);
        rd(8'h04, 32'h0000_FFFF);

        // Prescaled one-shot compare with interrupt
        wr(8'h04, 32'd3, 4'hF);
        wr(8'h0C, 32'd5, 4'hF);
        wr(8'h00, 32'h5, 4'hF);
        repeat (23) @(negedge clk);
        check("irq_before", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("irq_rise", {31'h0, irq}, 32'h1);
        rd(8'h08, 32'd6);
        repeat (3) @(negedge clk);
        rd(8'h08, 32'd7);
        rd(8'h10, 32'h1);
        wr(8'h10, 32'h1, 4'h1);
        check("irq_clear", {31'h0, irq}, 32'h0);
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h08, 32'h55, 4'hF);
        repeat (10) @(negedge clk);
        rd(8'h08, 32'h55);

        // Periodic mode, W1C colliding with a new match
        wr(8'h04, 32'd0, 4'hF);
        wr(8'h0C, 32'd2, 4'hF);
        wr(8'h08, 32'd0, 4'hF);
        wr(8'h10, 32'h3, 4'h1);
        wr(8'h00, 32'h3, 4'hF);
        for (int i = 0; i < 7; i++) rd(8'h08, 32'(i % 3));
        wr(8'h10, 32'h1, 4'h1);
        wr(8'h10, 32'h1, 4'h1);
        rd(8'h10, 32'h1);
        check("irq_gated", {31'h0, irq}, 32'h0);

        // 32-bit wrap without a match flag
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h0C, 32'd10, 4'hF);
        wr(8'h08, 32'hFFFF_FFFE, 4'hF);
        wr(8'h10, 32'h1, 4'h1);
        wr(8'h00, 32'h1, 4'hF);
        rd(8'h08, 32'hFFFF_FFFE); rd(8'h08, 32'hFFFF_FFFF);
        rd(8'h08, 32'h0);         rd(8'h08, 32'h1);
        rd(8'h10, 32'h0);
        wr(8'h00, 32'h0, 4'hF);

        // Partial COUNT write landing in a tick cycle
        wr(8'h04, 32'd3, 4'hF);
        wr(8'h0C, 32'd0, 4'hF);
        wr(8'h08, 32'd0, 4'hF);
        wr(8'h10, 32'h1, 4'h1);
        wr(8'h00, 32'h1, 4'hF);
        repeat (3) @(negedge clk);
        wr(8'h08, 32'h0000_0100, 4'b0010);
        rd(8'h08, 32'h0000_0100);
        repeat (3) @(negedge clk);
        rd(8'h08, 32'h0000_0101);
        rd(8'h10, 32'h0);
        wr(8'h00, 32'h0, 4'hF);

`ifdef TIMER_CAPTURE_EN
        // Input capture through the synchronizer
        wr(8'h04, 32'd0, 4'hF);
        wr(8'h0C, 32'hFFFF_FFFF, 4'hF);
        wr(8'h08, 32'd0, 4'hF);
        wr(8'h10, 32'h3, 4'h1);
        wr(8'h00, 32'h1, 4'hF);
        repeat (5) @(negedge clk);
        cap_in = 1'b1;
        repeat (2) @(negedge clk);
        cap_in = 1'b0;
        wr(8'h00, 32'h0, 4'hF);
        rd(8'h14, 32'd7);
        rd(8'h10, 32'h2);
`endif

        // Asynchronous reset drops a pending read response
        wr(8'h00, 32'h5, 4'hF);
        wr(8'h0C, 32'h1234, 4'hF);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'h0);
        bus.ren   = 1'b1;
        bus.raddr = 32'h0;
        @(posedge clk);
        #2;
        rst     = 1'b1;
        bus.ren = 1'b0;
        #1;
        check("async_rvalid", {31'h0, bus.rvalid}, 32'h0);
        @(negedge clk);
        check("async_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        rd(8'h00, 32'h0);
        rd(8'h0C, 32'hFFFF_FFFF);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain_end", 32'(exp_q.size()), 32'h0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
